// File: rtl/sb_pkg.sv
// Sideband link shared definitions: packet width, idle-gap length, receive FSM states and packet type.
`default_nettype none

package sb_pkg;

  localparam int SB_PACKET_WIDTH = 64;
  localparam int SB_GAP_CYCLES   = 32;

  typedef enum logic [1:0] {
    SB_RX_IDLE  = 2'd0,
    SB_RX_SHIFT = 2'd1,
    SB_RX_GAP   = 2'd2
  } sb_rx_state_e;

  typedef logic [SB_PACKET_WIDTH-1:0] sb_packet_t;

endpackage

`default_nettype wire

// File: rtl/sb_rx_out_stage.sv
// Single-entry valid/ready holding register for received sideband packets with overflow detection.
// Optional parity pulse on delivery when SB_RX_PARITY_CHECK_EN is defined.
`default_nettype none

module sb_rx_out_stage
  import sb_pkg::*;
(
  input  logic                       i_pll_clk,
  input  logic                       i_rst_n,
  input  logic                       i_load,
  input  logic [SB_PACKET_WIDTH-1:0] i_load_pkt,
  input  logic                       i_packet_ready,
  output logic [SB_PACKET_WIDTH-1:0] o_packet,
`ifdef SB_RX_PARITY_CHECK_EN
  output logic                       o_parity_err,
`endif
  output logic                       o_packet_valid,
  output logic                       o_overflow
);

  logic [SB_PACKET_WIDTH-1:0] packet_q, packet_d;
  logic                       valid_q, valid_d;
  logic                       overflow_q, overflow_d;
  logic                       accept;

  // The slot is reusable when empty or when its current occupant leaves this cycle.
  assign accept = i_load & (~valid_q | i_packet_ready);

  always_comb begin
    packet_d   = packet_q;
    valid_d    = valid_q;
    overflow_d = i_load & valid_q & ~i_packet_ready;
    if (accept) begin
      packet_d = i_load_pkt;
      valid_d  = 1'b1;
    end else if (valid_q && i_packet_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge i_pll_clk) begin
    if (!i_rst_n) begin
      packet_q   <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      packet_q   <= packet_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_packet       = packet_q;
  assign o_packet_valid = valid_q;
  assign o_overflow     = overflow_q;

`ifdef SB_RX_PARITY_CHECK_EN
  logic parity_q, parity_d;

  assign parity_d = accept & (^i_load_pkt);

  always_ff @(posedge i_pll_clk) begin
    if (!i_rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign o_parity_err = parity_q;
`endif

endmodule

`default_nettype wire

// File: rtl/sb_rx_deserializer.sv
// Sideband receive deserializer: LSB-first 64-bit packet assembly with 64-on/32-off framing checks.
// Optional macro SB_RX_PARITY_CHECK_EN adds the o_parity_err output.
`default_nettype none

module sb_rx_deserializer
  import sb_pkg::*;
(
  input  logic                       i_pll_clk,
  input  logic                       i_rst_n,
  input  logic                       i_rx_valid,
  input  logic                       i_rx_data,
  input  logic                       i_packet_ready,
  output logic [SB_PACKET_WIDTH-1:0] o_packet,
  output logic                       o_packet_valid,
  output logic                       o_frame_err,
  output logic                       o_overflow,
`ifdef SB_RX_PARITY_CHECK_EN
  output logic                       o_parity_err,
`endif
  output logic                       o_rx_idle
);

  localparam logic [1:0] S_IDLE  = SB_RX_IDLE;
  localparam logic [1:0] S_SHIFT = SB_RX_SHIFT;
  localparam logic [1:0] S_GAP   = SB_RX_GAP;

  localparam logic [6:0] LAST_BIT = 7'(SB_PACKET_WIDTH - 1);
  localparam logic [5:0] GAP_LAST = 6'(SB_GAP_CYCLES - 1);

  logic [1:0]                 state_q, state_d;
  logic [6:0]                 bit_cnt_q, bit_cnt_d;
  logic [5:0]                 gap_cnt_q, gap_cnt_d;
  logic [SB_PACKET_WIDTH-1:0] shift_q, shift_d;
  logic                       frame_err_q, frame_err_d;
  logic                       complete;
  logic [SB_PACKET_WIDTH-1:0] complete_pkt;

  // The top bit of shift_q is never written, so the final bit can be ORed in directly.
  assign complete_pkt = {i_rx_data, {(SB_PACKET_WIDTH-1){1'b0}}} | shift_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    complete    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rx_valid) begin
          shift_d    = '0;
          shift_d[0] = i_rx_data;
          bit_cnt_d  = 7'd1;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (i_rx_valid) begin
          if (bit_cnt_q == LAST_BIT) begin
            complete  = 1'b1;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end else begin
            shift_d[bit_cnt_q[5:0]] = i_rx_data;
            bit_cnt_d               = bit_cnt_q + 7'd1;
          end
        end else begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (i_rx_valid) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          shift_d[0]  = i_rx_data;
          bit_cnt_d   = 7'd1;
          state_d     = S_SHIFT;
        end else begin
          gap_cnt_d = gap_cnt_q + 6'd1;
          if (gap_cnt_q == GAP_LAST) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_pll_clk) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_frame_err = frame_err_q;
  assign o_rx_idle   = (state_q == S_IDLE);

  sb_rx_out_stage u_out_stage (
    .i_pll_clk      (i_pll_clk),
    .i_rst_n        (i_rst_n),
    .i_load         (complete),
    .i_load_pkt     (complete_pkt),
    .i_packet_ready (i_packet_ready),
    .o_packet       (o_packet),
`ifdef SB_RX_PARITY_CHECK_EN
    .o_parity_err   (o_parity_err),
`endif
    .o_packet_valid (o_packet_valid),
    .o_overflow     (o_overflow)
  );

endmodule

`default_nettype wire

// File: tb/tb_sb_rx_deserializer.sv
// Directed bench for sb_rx_deserializer: table of clean packets plus framing, overflow and reset sequences.
`default_nettype none

module tb_sb_rx_deserializer;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic        rx_data;
  logic        ready;
  logic [63:0] packet;
  logic        packet_valid;
  logic        frame_err;
  logic        overflow;
  logic        rx_idle;
`ifdef SB_RX_PARITY_CHECK_EN
  logic        parity_err;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int fe_cnt   = 0;
  int of_cnt   = 0;
  int pe_cnt   = 0;

  sb_rx_deserializer dut (
    .i_pll_clk      (clk),
    .i_rst_n        (rst_n),
    .i_rx_valid     (rx_valid),
    .i_rx_data      (rx_data),
    .i_packet_ready (ready),
    .o_packet       (packet),
    .o_packet_valid (packet_valid),
    .o_frame_err    (frame_err),
    .o_overflow     (overflow),
`ifdef SB_RX_PARITY_CHECK_EN
    .o_parity_err   (parity_err),
`endif
    .o_rx_idle      (rx_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overflow) of_cnt++;
`ifdef SB_RX_PARITY_CHECK_EN
    if (parity_err) pe_cnt++;
`endif
  end

  typedef struct {
    logic [63:0] pkt;
    logic [63:0] exp_pkt;
    logic        exp_par;
  } vec_t;

  vec_t vecs [7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [63:0] p, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rx_valid = 1'b1;
      rx_data  = p[i];
      step();
    end
    rx_valid = 1'b0;
    rx_data  = 1'b0;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    rx_data  = 1'b0;
    repeat (n) step();
  endtask

  int fe0, of0, pe0;

  initial begin
    vecs[0] = '{64'hA5A5_0000_FFFF_1234, 64'hA5A5_0000_FFFF_1234, 1'b1};
    vecs[1] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000, 1'b0};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 1'b0};
    vecs[4] = '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[5] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1};
    vecs[6] = '{64'h0000_0000_0000_0003, 64'h0000_0000_0000_0003, 1'b0};

    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 1'b0; ready = 1'b0;
    step(); step();
    chk("reset_packet", packet, 64'h0);
    chk("reset_valid", {63'h0, packet_valid}, 64'h0);
    chk("reset_frame_err", {63'h0, frame_err}, 64'h0);
    chk("reset_overflow", {63'h0, overflow}, 64'h0);
    chk("reset_rx_idle", {63'h0, rx_idle}, 64'h1);
    rst_n = 1'b1;
    step();

    // Clean packets, each consumed one cycle after delivery, followed by an exact 32-cycle gap.
    for (int v = 0; v < 7; v++) begin
      fe0 = fe_cnt; of0 = of_cnt;
      ready = 1'b0;
      send_bits(vecs[v].pkt, 0, 64);
      chk("clean_valid", {63'h0, packet_valid}, 64'h1);
      chk("clean_packet", packet, vecs[v].exp_pkt);
      chk("clean_rx_idle_low", {63'h0, rx_idle}, 64'h0);
`ifdef SB_RX_PARITY_CHECK_EN
      chk("clean_parity", {63'h0, parity_err}, {63'h0, vecs[v].exp_par});
`endif
      ready = 1'b1;
      step();
      ready = 1'b0;
      chk("clean_consumed", {63'h0, packet_valid}, 64'h0);
`ifdef SB_RX_PARITY_CHECK_EN
      chk("clean_parity_pulse_end", {63'h0, parity_err}, 64'h0);
`endif
      idle(30);
      chk("gap31_not_idle", {63'h0, rx_idle}, 64'h0);
      idle(1);
      chk("gap32_idle", {63'h0, rx_idle}, 64'h1);
      chk("clean_no_frame_err", fe_cnt - fe0, 64'h0);
      chk("clean_no_overflow", of_cnt - of0, 64'h0);
    end

    // Truncated packet: 40 bits then valid drops.
    fe0 = fe_cnt;
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 40);
    chk("trunc_rx_idle_low", {63'h0, rx_idle}, 64'h0);
    idle(1);
    chk("trunc_frame_err", {63'h0, frame_err}, 64'h1);
    idle(1);
    chk("trunc_frame_err_pulse", {63'h0, frame_err}, 64'h0);
    idle(30);
    chk("trunc_gap_not_idle", {63'h0, rx_idle}, 64'h0);
    idle(1);
    chk("trunc_gap_idle", {63'h0, rx_idle}, 64'h1);
    chk("trunc_no_valid", {63'h0, packet_valid}, 64'h0);
    chk("trunc_one_err", fe_cnt - fe0, 64'h1);

    // Gap violation 10 cycles into GAP.
    ready = 1'b0;
    send_bits(64'h1357_9BDF_0246_8ACE, 0, 64);
    chk("gapv_first_valid", {63'h0, packet_valid}, 64'h1);
    fe0 = fe_cnt;
    ready = 1'b1;
    idle(10);
    ready = 1'b0;
    send_bits(64'hCAFE_BABE_DEAD_BEEF, 0, 1);
    chk("gapv_frame_err", {63'h0, frame_err}, 64'h1);
    send_bits(64'hCAFE_BABE_DEAD_BEEF, 1, 64);
    chk("gapv_valid", {63'h0, packet_valid}, 64'h1);
    chk("gapv_packet", packet, 64'hCAFE_BABE_DEAD_BEEF);
    chk("gapv_one_err", fe_cnt - fe0, 64'h1);
    ready = 1'b1;
    idle(32);
    ready = 1'b0;
    chk("gapv_idle", {63'h0, rx_idle}, 64'h1);

    // Overflow: second packet dropped while the first is held.
    of0 = of_cnt; pe0 = pe_cnt;
    send_bits(64'hDEAD_BEEF_CAFE_F00D, 0, 64);
    idle(32);
    send_bits(64'h0000_0000_0000_0001, 0, 64);
    chk("ovf_pulse", {63'h0, overflow}, 64'h1);
    chk("ovf_valid", {63'h0, packet_valid}, 64'h1);
    chk("ovf_packet_kept", packet, 64'hDEAD_BEEF_CAFE_F00D);
    idle(1);
    chk("ovf_pulse_end", {63'h0, overflow}, 64'h0);
    chk("ovf_packet_hold", packet, 64'hDEAD_BEEF_CAFE_F00D);
    chk("ovf_one_pulse", of_cnt - of0, 64'h1);
`ifdef SB_RX_PARITY_CHECK_EN
    chk("ovf_no_parity", pe_cnt - pe0, 64'h0);
`endif
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    chk("ovf_consumed", {63'h0, packet_valid}, 64'h0);
    idle(30);

    // Consume and complete in the same cycle.
    of0 = of_cnt;
    send_bits(64'h1111_2222_3333_4444, 0, 64);
    idle(32);
    send_bits(64'h5555_6666_7777_8888, 0, 63);
    ready    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 1'b0;
    step();
    rx_valid = 1'b0;
    chk("simul_valid", {63'h0, packet_valid}, 64'h1);
    chk("simul_packet", packet, 64'h5555_6666_7777_8888);
    chk("simul_no_overflow", of_cnt - of0, 64'h0);
    idle(1);
    ready = 1'b0;
    chk("simul_drained", {63'h0, packet_valid}, 64'h0);
    idle(31);

    // Reset mid-packet with a held packet present.
    send_bits(64'h0F0F_0F0F_0F0F_0F0F, 0, 64);
    idle(32);
    send_bits(64'hFFFF_FFFF_FFFF_FFFF, 0, 30);
    fe0 = fe_cnt;
    rst_n    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 1'b1;
    step();
    chk("rst_packet", packet, 64'h0);
    chk("rst_valid", {63'h0, packet_valid}, 64'h0);
    chk("rst_frame_err", {63'h0, frame_err}, 64'h0);
    chk("rst_overflow", {63'h0, overflow}, 64'h0);
    chk("rst_rx_idle", {63'h0, rx_idle}, 64'h1);
    rst_n = 1'b1;
    idle(3);
    chk("rst_no_err", fe_cnt - fe0, 64'h0);
    chk("rst_still_idle", {63'h0, rx_idle}, 64'h1);
    send_bits(64'h0123_4567_89AB_CDEF, 0, 64);
    chk("rst_after_valid", {63'h0, packet_valid}, 64'h1);
    chk("rst_after_packet", packet, 64'h0123_4567_89AB_CDEF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
